// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction-fetch front end. Holds the PC, fetches 32-bit words over a
//   req/ack instruction-memory port and presents one instruction at a time,
//   qualified by o_instr_valid, holding it while decode stalls. Branch/jump
//   redirects retarget the PC; any fetch already in flight is drained and its
//   data discarded so that no pre-redirect instruction is ever presented.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   o_imem_req       fetch request, held until i_imem_ack
//   o_imem_addr      fetch address, stable while a request is pending
//   i_imem_ack       transfer completes when o_imem_req && i_imem_ack
//   i_imem_rdata     instruction word, valid in the ack cycle
//   i_stall          decode cannot accept the presented instruction
//   i_redirect_en    branch/jump taken (one-cycle pulse)
//   i_redirect_pc    redirect target
//   o_instr_valid    instruction and field outputs are live
//   o_instr          registered instruction word
//   o_opcode/o_rs/o_rt/o_rd/o_funct  field slices of o_instr
//   o_pc_out         address of the presented instruction
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned RESET_PC = 32'd0,
  parameter int unsigned PC_STEP  = 32'd4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_stall,
  input  logic              i_redirect_en,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_instr_valid,
  output logic [31:0]       o_instr,
  output logic [5:0]        o_opcode,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [5:0]        o_funct,
  output logic [ADDR_W-1:0] o_pc_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP_W  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic                r_imem_req;
  logic [31:0]         r_instr;
  logic [ADDR_W-1:0]   r_pc_out;
  logic                r_instr_valid;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_req_nxt;
  logic [31:0]         w_instr_nxt;
  logic [ADDR_W-1:0]   w_pc_out_nxt;
  logic                w_valid_nxt;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath values; everything defaults to "hold".
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_addr_nxt   = r_imem_addr;
    w_instr_nxt  = r_instr;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_instr_valid;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        // A redirect seen before the first fetch retargets that fetch.
        if (i_redirect_en) begin
          w_pc_nxt   = i_redirect_pc;
          w_addr_nxt = i_redirect_pc;
        end else begin
          w_addr_nxt = r_pc;
        end
      end
      ST_FETCH: begin
        if (i_imem_ack && i_redirect_en) begin
          // Completed word is stale: drop it and re-request at the target.
          w_pc_nxt    = i_redirect_pc;
          w_addr_nxt  = i_redirect_pc;
          w_state_nxt = ST_FETCH;
        end else if (i_imem_ack) begin
          w_instr_nxt  = i_imem_rdata;
          w_pc_out_nxt = r_imem_addr;
          w_pc_nxt     = r_pc + PC_STEP_W;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = ST_HOLD;
        end else if (i_redirect_en) begin
          // Address must stay put while the old request is outstanding.
          w_pc_nxt    = i_redirect_pc;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (i_imem_ack) begin
          w_state_nxt = ST_FETCH;
          // The most recent redirect target wins, even in the ack cycle.
          if (i_redirect_en) begin
            w_pc_nxt   = i_redirect_pc;
            w_addr_nxt = i_redirect_pc;
          end else begin
            w_addr_nxt = r_pc;
          end
        end else begin
          w_state_nxt = ST_DRAIN;
          if (i_redirect_en) begin
            w_pc_nxt = i_redirect_pc;
          end else begin
            w_pc_nxt = r_pc;
          end
        end
      end
      ST_HOLD: begin
        if (i_redirect_en) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = i_redirect_pc;
          w_addr_nxt  = i_redirect_pc;
          w_state_nxt = ST_FETCH;
        end else if (!i_stall) begin
          w_valid_nxt = 1'b0;
          w_addr_nxt  = r_pc;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = RESET_PC_W;
        w_addr_nxt  = ADDR_ZERO;
        w_valid_nxt = 1'b0;
      end
    endcase
    // Request is registered from the next state so it is high exactly in FETCH/DRAIN.
    w_req_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DRAIN);
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC_W;
      r_imem_addr   <= ADDR_ZERO;
      r_imem_req    <= 1'b0;
      r_instr       <= 32'd0;
      r_pc_out      <= ADDR_ZERO;
      r_instr_valid <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_imem_addr   <= w_addr_nxt;
      r_imem_req    <= w_req_nxt;
      r_instr       <= w_instr_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_instr_valid <= w_valid_nxt;
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr_valid = r_instr_valid;
  assign o_instr       = r_instr;
  assign o_pc_out      = r_pc_out;
  // Field slices are only meaningful while o_instr_valid is high.
  assign o_opcode      = r_instr[31:26];
  assign o_rs          = r_instr[25:21];
  assign o_rt          = r_instr[20:16];
  assign o_rd          = r_instr[15:11];
  assign o_funct       = r_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit: sequential fetch, decode stall,
//   redirects with and without a pending transfer, PC wrap, reset mid-drain
//   and redirect before the first fetch.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] pc_out;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'd0), .PC_STEP(32'd4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .i_stall      (stall),
    .i_redirect_en(redirect_en),
    .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid),
    .o_instr      (instr),
    .o_opcode     (opcode),
    .o_rs         (rs),
    .o_rt         (rt),
    .o_rd         (rd),
    .o_funct      (funct),
    .o_pc_out     (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents used by the bench: distinct per address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", imem_addr); else n_pass++;
    n_total++; if (instr !== 32'h0) $display("FAIL rst_instr got %h want 0", instr); else n_pass++;
    n_total++; if (pc_out !== 32'h0) $display("FAIL rst_pc_out got %h want 0", pc_out); else n_pass++;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else n_pass++;
    cyc();
    n_total++; if (imem_req !== 1'b1) $display("FAIL first_req got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL first_addr got %h want 0", imem_addr); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k) * 32'd4;
      w = word_at(a);
      n_total++; if (imem_addr !== a) $display("FAIL seq_addr got %h want %h", imem_addr, a); else n_pass++;
      n_total++; if (imem_req !== 1'b1) $display("FAIL seq_req got %b want 1", imem_req); else n_pass++;
      imem_ack = 1'b1; imem_rdata = w;
      cyc();
      imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
      n_total++; if (instr_valid !== 1'b1) $display("FAIL seq_valid got %b want 1", instr_valid); else n_pass++;
      n_total++; if (instr !== w) $display("FAIL seq_instr got %h want %h", instr, w); else n_pass++;
      n_total++; if (pc_out !== a) $display("FAIL seq_pc_out got %h want %h", pc_out, a); else n_pass++;
      n_total++; if (opcode !== w[31:26]) $display("FAIL seq_opcode got %h want %h", opcode, w[31:26]); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL seq_hold_req got %b want 0", imem_req); else n_pass++;
      cyc();
      n_total++; if (instr_valid !== 1'b0) $display("FAIL seq_consumed got %b want 0", instr_valid); else n_pass++;
    end
  endtask

  task automatic test_stall_hold();
    // add $t0,$t1,$t2 : rs=9, rt=10, rd=8, funct=0x20
    n_total++; if (imem_addr !== 32'hC) $display("FAIL stall_addr got %h want c", imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'h012A_4020; stall = 1'b1;
    cyc();
    imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (instr_valid !== 1'b1) $display("FAIL stall_valid got %b want 1", instr_valid); else n_pass++;
      n_total++; if (instr !== 32'h012A_4020) $display("FAIL stall_instr got %h want 012a4020", instr); else n_pass++;
      n_total++; if (pc_out !== 32'hC) $display("FAIL stall_pc_out got %h want c", pc_out); else n_pass++;
      n_total++; if (opcode !== 6'd0) $display("FAIL stall_opcode got %h want 0", opcode); else n_pass++;
      n_total++; if (rs !== 5'd9) $display("FAIL stall_rs got %0d want 9", rs); else n_pass++;
      n_total++; if (rt !== 5'd10) $display("FAIL stall_rt got %0d want 10", rt); else n_pass++;
      n_total++; if (rd !== 5'd8) $display("FAIL stall_rd got %0d want 8", rd); else n_pass++;
      n_total++; if (funct !== 6'h20) $display("FAIL stall_funct got %h want 20", funct); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req got %b want 0", imem_req); else n_pass++;
      if (i < 4) cyc();
    end
    stall = 1'b0;
    cyc();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL unstall_valid got %b want 0", instr_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL unstall_req got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h10) $display("FAIL unstall_addr got %h want 10", imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_pending();
    redirect_en = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (imem_req !== 1'b1) $display("FAIL drain_req got %b want 1", imem_req); else n_pass++;
      n_total++; if (imem_addr !== 32'h10) $display("FAIL drain_addr got %h want 10", imem_addr); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", instr_valid); else n_pass++;
      if (i < 2) cyc();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL drained_valid got %b want 0", instr_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL redir_req got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h100) $display("FAIL redir_addr got %h want 100", imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = word_at(32'h100);
    cyc();
    imem_ack = 1'b0;
    n_total++; if (instr !== word_at(32'h100)) $display("FAIL redir_instr got %h want %h", instr, word_at(32'h100)); else n_pass++;
    n_total++; if (pc_out !== 32'h100) $display("FAIL redir_pc_out got %h want 100", pc_out); else n_pass++;
    cyc();
    n_total++; if (imem_addr !== 32'h104) $display("FAIL redir_next_addr got %h want 104", imem_addr); else n_pass++;
  endtask

  task automatic test_drain_retarget();
    redirect_en = 1'b1; redirect_pc = 32'h200;
    cyc();
    n_total++; if (imem_addr !== 32'h104) $display("FAIL retgt_addr1 got %h want 104", imem_addr); else n_pass++;
    redirect_pc = 32'h300;
    cyc();
    redirect_en = 1'b0;
    n_total++; if (imem_addr !== 32'h104) $display("FAIL retgt_addr2 got %h want 104", imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = word_at(32'h104);
    cyc();
    imem_ack = 1'b0;
    n_total++; if (imem_addr !== 32'h300) $display("FAIL retgt_addr got %h want 300", imem_addr); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL retgt_valid got %b want 0", instr_valid); else n_pass++;
  endtask

  task automatic test_redirect_with_ack();
    imem_ack = 1'b1; imem_rdata = word_at(32'h300);
    redirect_en = 1'b1; redirect_pc = 32'h40;
    cyc();
    imem_ack = 1'b0; redirect_en = 1'b0;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL ackredir_valid got %b want 0", instr_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL ackredir_req got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h40) $display("FAIL ackredir_addr got %h want 40", imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = word_at(32'h40);
    cyc();
    imem_ack = 1'b0;
    n_total++; if (pc_out !== 32'h40) $display("FAIL ackredir_pc_out got %h want 40", pc_out); else n_pass++;
    n_total++; if (instr !== word_at(32'h40)) $display("FAIL ackredir_instr got %h want %h", instr, word_at(32'h40)); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    // Redirect while stalled in HOLD takes priority over the stall.
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    stall = 1'b0; redirect_en = 1'b0;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL holdredir_valid got %b want 0", instr_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL holdredir_addr got %h want fffffffc", imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = word_at(32'hFFFF_FFFC);
    cyc();
    imem_ack = 1'b0;
    n_total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_out got %h want fffffffc", pc_out); else n_pass++;
    cyc();
    n_total++; if (imem_req !== 1'b1) $display("FAIL wrap_req got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h want 0", imem_addr); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    redirect_en = 1'b1; redirect_pc = 32'h80;
    cyc();
    redirect_en = 1'b0;
    n_total++; if (imem_req !== 1'b1) $display("FAIL rd_req_pre got %b want 1", imem_req); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rd_req got %b want 0", imem_req); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rd_valid got %b want 0", instr_valid); else n_pass++;
    cyc();
    rst_n = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rd_idle_req got %b want 0", imem_req); else n_pass++;
    cyc();
    n_total++; if (imem_req !== 1'b1) $display("FAIL rd_first_req got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rd_first_addr got %h want 0", imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = word_at(32'h0);
    cyc();
    imem_ack = 1'b0;
    n_total++; if (pc_out !== 32'h0) $display("FAIL rd_pc_out got %h want 0", pc_out); else n_pass++;
    n_total++; if (instr_valid !== 1'b1) $display("FAIL rd_valid2 got %b want 1", instr_valid); else n_pass++;
  endtask

  task automatic test_idle_redirect();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    redirect_en = 1'b1; redirect_pc = 32'h500;
    cyc();
    redirect_en = 1'b0;
    n_total++; if (imem_req !== 1'b1) $display("FAIL idleredir_req got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h500) $display("FAIL idleredir_addr got %h want 500", imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = word_at(32'h500);
    cyc();
    imem_ack = 1'b0;
    n_total++; if (pc_out !== 32'h500) $display("FAIL idleredir_pc_out got %h want 500", pc_out); else n_pass++;
    cyc();
    n_total++; if (imem_addr !== 32'h504) $display("FAIL idleredir_next got %h want 504", imem_addr); else n_pass++;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_pending();
    test_drain_retarget();
    test_redirect_with_ack();
    test_pc_wrap();
    test_reset_mid_drain();
    test_idle_redirect();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
